alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Execute-issue stage directly upstream of the 32-bit ALU (op set AND/OR/ADD/SUB/SLT).
- Accepts decoded RV32I fields plus register-file operands over a valid/ready handshake.
- Derives the 3-bit ALU op, selects operand B (rs2 or immediate), and presents registered a/b/op to the ALU.
- 2-entry skid buffer; full throughput, no combinational ready path.

Parameters:
- WIDTH, 32, operand/immediate width.
- STAT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; registered.
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25]; only bit 5 is used.
- rs1_val  in  WIDTH  register operand 1.
- rs2_val  in  WIDTH  register operand 2.
- imm  in  WIDTH  sign-extended immediate.
- out_valid  out  1  alu_a/alu_b/alu_op are valid.
- out_ready  in  1  downstream (ALU/EX latch) consumes this cycle.
- alu_a  out  WIDTH  ALU operand a.
- alu_b  out  WIDTH  ALU operand b.
- alu_op  out  3  ALU op code.
- out_illegal  out  1  entry is an unsupported instruction.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, in_ready=1, alu_a=0, alu_b=0, alu_op=3'b010, out_illegal=0.
  - Both buffer entries are emptied; any in-flight entry is discarded.
- Op codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- Decode, R-type (opcode 0110011), b=rs2_val:
  - funct3 000 → SUB if funct7[5]=1, else ADD.
  - funct3 111 → AND; 110 → OR; 010 → SLT.
- Decode, I-type ALU (0010011), b=imm:
  - funct3 000 → ADD (funct7 ignored); 111 → AND; 110 → OR; 010 → SLT.
- Decode, load (0000011) or store (0100011): ADD, b=imm.
- Decode, branch (1100011): SUB, b=rs2_val (ALU zero gives equality).
- Illegal: any other opcode or funct3.
  - Entry still issues with out_illegal=1, alu_a=0, alu_b=0, op=ADD.
  - ALU result is 0; the entry is never dropped.
- Operand A is always rs1_val.
- Handshake:
  - Transfer occurs when valid&&ready are both high at a rising edge.
  - out_* hold stable while out_valid && !out_ready.
- Latency: an entry accepted at edge N appears on out_* after edge N when the output register is empty or draining.
- Buffer states (output register OUT, skid register SKID):
  - EMPTY: OUT=0, SKID=0.
  - ONE: OUT=1, SKID=0.
  - FULL: OUT=1, SKID=1.
- Transitions:
  - EMPTY → ONE on accept.
  - ONE + accept + out_ready → ONE, new data loaded into OUT.
  - ONE + accept + !out_ready → FULL, new data into SKID.
  - ONE + no accept + out_ready → EMPTY.
  - FULL + out_ready → ONE, SKID moves to OUT.
  - FULL + !out_ready → FULL.
- in_ready = !FULL, registered from next state; accept is impossible in FULL.
- Ordering is strictly FIFO; no entry is duplicated or lost.
- Simultaneous accept and drain in ONE keeps throughput at 1 per cycle.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- When defined, the block adds:
  - outputs stat_issued[STAT_W-1:0] and stat_illegal[STAT_W-1:0];
  - stat_issued increments on each out_valid&&out_ready;
  - stat_illegal increments additionally when out_illegal=1 on that transfer;
  - both counters saturate at all-ones, never wrap, and are cleared to 0 by reset.
- When undefined: no counter ports and no counter logic; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - ALU op constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, 3-bit);
  - opcode constants (OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH, 7-bit);
  - a struct/typedef bundling {a, b, op, illegal} for buffer entries.
- Sub-module alu_ctl_decode: purely combinational, maps opcode/funct3/funct7[5] to {op, use_imm, illegal}.
- The top holds the skid buffer and operand mux.

Test Plan:
- Reset, then R-type funct3=000 funct7=0100000, rs1=7, rs2=7 with out_ready=1 → next cycle out_valid=1, op=110, a=7, b=7; ALU z=0.
- I-type funct3=010, rs1=-5 (0xFFFFFFFB), imm=3 → op=111, b=3; ALU z=1.
- Backpressure: out_ready=0 and three back-to-back valid inputs → first two accepted, in_ready=0 after the second. Then raise out_ready → outputs appear in order with no loss.
- Illegal opcode 1111111 → out_illegal=1, a=0, b=0, op=010. With ALU_ISSUE_STATS_EN: stat_illegal=1, stat_issued=1.
- Assert reset while FULL → out_valid=0 and in_ready=1 immediately, without waiting for an edge. A subsequent input issues normally.
- Streaming 100 random legal instructions with out_ready=1 → one output per cycle; a/b/op match the decode oracle for every entry.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared definitions for the ALU issue stage: ALU op codes,
//               RV32I major opcodes and the buffered issue-entry bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W = 32;

    // ALU operation encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // One issued instruction as seen by the ALU
    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [2:0]       op;
        logic             illegal;
    } issue_entry_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_ctl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctl_decode
// Description : Combinational ALU control decode. Maps opcode / funct3 /
//               funct7[5] to the ALU op, the operand-B source and an illegal
//               flag. Illegal encodings report op=ADD and use_imm=0.
// Ports       : opcode[6:0], funct3[2:0], funct7_b5 in;
//               op[2:0], use_imm, illegal out.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [2:0] op,
    output logic       use_imm,
    output logic       illegal
);

    always_comb begin
        op      = ALU_ADD;
        use_imm = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                case (funct3)
                    3'b000:  op = funct7_b5 ? ALU_SUB : ALU_ADD;
                    3'b111:  op = ALU_AND;
                    3'b110:  op = ALU_OR;
                    3'b010:  op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_ITYPE: begin
                use_imm = 1'b1;
                // ADDI has no SUB form, so funct7 is not consulted here
                case (funct3)
                    3'b000:  op = ALU_ADD;
                    3'b111:  op = ALU_AND;
                    3'b110:  op = ALU_OR;
                    3'b010:  op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                op      = ALU_ADD;  // address generation
                use_imm = 1'b1;
            end
            OPC_BRANCH: begin
                op = ALU_SUB;       // ALU zero flag gives equality
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            op      = ALU_ADD;
            use_imm = 1'b0;
        end
    end

endmodule : alu_ctl_decode
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Execute-issue stage in front of the 32-bit ALU. Decodes the
//               ALU op, selects operand B and presents registered a/b/op
//               through a 2-entry skid buffer (output register + skid
//               register). in_ready is registered, so there is no
//               combinational path from out_ready to in_ready.
// Ports       : clk, reset (async, active high);
//               in_valid/in_ready, opcode, funct3, funct7, rs1_val, rs2_val,
//               imm (upstream); out_valid/out_ready, alu_a, alu_b, alu_op,
//               out_illegal (downstream).
// Options     : ALU_ISSUE_STATS_EN adds saturating stat_issued/stat_illegal
//               counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [WIDTH-1:0]  rs1_val,
    input  logic [WIDTH-1:0]  rs2_val,
    input  logic [WIDTH-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [2:0]        alu_op,
`ifdef ALU_ISSUE_STATS_EN
    output logic [STAT_W-1:0] stat_issued,
    output logic [STAT_W-1:0] stat_illegal,
`endif
    output logic              out_illegal
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } buf_state_e;

    localparam issue_entry_t ENTRY_RESET = '{a: '0, b: '0, op: ALU_ADD, illegal: 1'b0};

    logic [2:0]   dec_op;
    logic         dec_use_imm;
    logic         dec_illegal;
    issue_entry_t new_entry;
    logic         accept;

    buf_state_e   state_q,     state_d;
    issue_entry_t out_q,       out_d;
    issue_entry_t skid_q,      skid_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q,  in_ready_d;

    // Only funct7[5] participates in decode
    logic unused_funct7_bits;
    assign unused_funct7_bits = ^{funct7[6], funct7[4:0]};

    alu_ctl_decode u_decode (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_b5 (funct7[5]),
        .op        (dec_op),
        .use_imm   (dec_use_imm),
        .illegal   (dec_illegal)
    );

    // Illegal entries issue with zeroed operands so the ALU result is 0
    always_comb begin
        new_entry.a       = dec_illegal ? '0 : rs1_val;
        new_entry.b       = dec_illegal ? '0 : (dec_use_imm ? imm : rs2_val);
        new_entry.op      = dec_op;
        new_entry.illegal = dec_illegal;
    end

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    out_d   = new_entry;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && out_ready) begin
                    out_d = new_entry;
                end else if (accept) begin
                    skid_d  = new_entry;
                    state_d = S_FULL;
                end else if (out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so no accept can coincide
                if (out_ready) begin
                    out_d   = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        out_valid_d = (state_d != S_EMPTY);
        in_ready_d  = (state_d != S_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            out_q       <= ENTRY_RESET;
            skid_q      <= ENTRY_RESET;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign alu_a       = out_q.a;
    assign alu_b       = out_q.b;
    assign alu_op      = out_q.op;
    assign out_illegal = out_q.illegal;

`ifdef ALU_ISSUE_STATS_EN
    logic [STAT_W-1:0] stat_issued_q,  stat_issued_d;
    logic [STAT_W-1:0] stat_illegal_q, stat_illegal_d;

    always_comb begin
        stat_issued_d  = stat_issued_q;
        stat_illegal_d = stat_illegal_q;
        if (out_valid_q && out_ready) begin
            if (!(&stat_issued_q)) begin
                stat_issued_d = stat_issued_q + STAT_W'(1);
            end
            if (out_q.illegal && !(&stat_illegal_q)) begin
                stat_illegal_d = stat_illegal_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued_q  <= '0;
            stat_illegal_q <= '0;
        end else begin
            stat_issued_q  <= stat_issued_d;
            stat_illegal_q <= stat_illegal_d;
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_illegal = stat_illegal_q;
`else
    logic [STAT_W-1:0] unused_stat_w;
    assign unused_stat_w = '0;
`endif

endmodule : alu_issue_stage
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Self-checking bench for alu_issue_stage. A queue-based
//               reference tracks in-flight instructions; every cycle the
//               DUT's valid/ready and head-of-queue outputs are compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_val, rs2_val, imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        out_illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_issued, stat_illegal;
`endif

    alu_issue_stage #(.WIDTH(32), .STAT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .imm         (imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
`ifdef ALU_ISSUE_STATS_EN
        .stat_issued (stat_issued),
        .stat_illegal(stat_illegal),
`endif
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        ill;
    } exp_t;

    exp_t mq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_issued  = 0;
    int   exp_illegal = 0;

    task automatic chk(string tag, logic [63:0] act, logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, expv, $time);
        end
    endtask

    // Reference behaviour straight from the instruction-set rules
    function automatic exp_t ref_issue(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                                       logic [31:0] r1, logic [31:0] r2, logic [31:0] im);
        exp_t        e;
        logic        legal;
        logic [2:0]  op;
        logic [31:0] b;
        legal = 1'b1;
        op    = 3'b010;
        b     = r2;
        if (opc == 7'h33 || opc == 7'h13) begin
            b = (opc == 7'h13) ? im : r2;
            if (f3 == 3'd0)      op = (opc == 7'h33 && f7[5]) ? 3'b110 : 3'b010;
            else if (f3 == 3'd7) op = 3'b000;
            else if (f3 == 3'd6) op = 3'b001;
            else if (f3 == 3'd2) op = 3'b111;
            else                 legal = 1'b0;
        end else if (opc == 7'h03 || opc == 7'h23) begin
            op = 3'b010;
            b  = im;
        end else if (opc == 7'h63) begin
            op = 3'b110;
            b  = r2;
        end else begin
            legal = 1'b0;
        end
        if (legal) begin
            e.a = r1; e.b = b; e.op = op; e.ill = 1'b0;
        end else begin
            e.a = '0; e.b = '0; e.op = 3'b010; e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic check_state(string tag);
        chk({tag, ".out_valid"}, out_valid, mq.size() > 0);
        chk({tag, ".in_ready"},  in_ready,  mq.size() < 2);
        if (mq.size() > 0) begin
            chk({tag, ".alu_a"},   alu_a,       mq[0].a);
            chk({tag, ".alu_b"},   alu_b,       mq[0].b);
            chk({tag, ".alu_op"},  alu_op,      mq[0].op);
            chk({tag, ".illegal"}, out_illegal, mq[0].ill);
        end
`ifdef ALU_ISSUE_STATS_EN
        chk({tag, ".stat_issued"},  stat_issued,  exp_issued);
        chk({tag, ".stat_illegal"}, stat_illegal, exp_illegal);
`endif
    endtask

    // One clock: update the reference with the handshake seen at the edge
    task automatic step(string tag);
        exp_t e;
        bit   acc, drn;
        e   = ref_issue(opcode, funct3, funct7, rs1_val, rs2_val, imm);
        acc = in_valid && (mq.size() < 2);
        drn = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (drn) begin
            if (exp_issued < 65535) exp_issued++;
            if (mq[0].ill && exp_illegal < 65535) exp_illegal++;
            void'(mq.pop_front());
        end
        if (acc) mq.push_back(e);
        #1;
        check_state(tag);
    endtask

    task automatic set_in(logic v, logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                          logic [31:0] r1, logic [31:0] r2, logic [31:0] im);
        in_valid = v; opcode = opc; funct3 = f3; funct7 = f7;
        rs1_val = r1; rs2_val = r2; imm = im;
    endtask

    task automatic rand_instr(bit legal_only);
        logic [2:0] ok3[4];
        logic [2:0] bad3[4];
        logic [6:0] opc;
        int         k;
        ok3  = '{3'd0, 3'd7, 3'd6, 3'd2};
        bad3 = '{3'd1, 3'd3, 3'd4, 3'd5};
        k = legal_only ? $urandom_range(0, 5) : $urandom_range(0, 7);
        funct3  = 3'($urandom);
        funct7  = 7'($urandom);
        rs1_val = $urandom;
        rs2_val = $urandom;
        imm     = $urandom;
        case (k)
            0, 5: begin opcode = 7'h33; funct3 = ok3[$urandom_range(0, 3)]; end
            1:    begin opcode = 7'h13; funct3 = ok3[$urandom_range(0, 3)]; end
            2:    opcode = ($urandom_range(0, 1) == 0) ? 7'h03 : 7'h23;
            3:    opcode = 7'h63;
            4:    begin opcode = 7'h13; funct3 = 3'd0; end
            6: begin
                opc = 7'($urandom);
                while (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 ||
                       opc == 7'h23 || opc == 7'h63) opc = 7'($urandom);
                opcode = opc;
            end
            default: begin
                opcode = ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h13;
                funct3 = bad3[$urandom_range(0, 3)];
            end
        endcase
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        set_in(1'b0, 7'h0, 3'd0, 7'h0, 32'h0, 32'h0, 32'h0);
        #2;
        check_state("rst");
        chk("rst.alu_op", alu_op, 3'b010);
        chk("rst.alu_a",  alu_a,  32'h0);
        chk("rst.alu_b",  alu_b,  32'h0);
        #1 reset = 1'b0;
        step("idle");

        // R-type SUB 7-7
        out_ready = 1'b1;
        set_in(1'b1, 7'h33, 3'd0, 7'b0100000, 32'd7, 32'd7, 32'd99);
        step("sub");
        chk("sub.op_lit", alu_op, 3'b110);
        chk("sub.zero", alu_a - alu_b, 32'h0);

        // I-type SLTI -5 < 3
        set_in(1'b1, 7'h13, 3'd2, 7'h7F, 32'hFFFF_FFFB, 32'd100, 32'd3);
        step("slti");
        chk("slti.op_lit", alu_op, 3'b111);
        chk("slti.lt", ($signed(alu_a) < $signed(alu_b)), 1'b1);

        // Backpressure: three back-to-back offers with out_ready low
        set_in(1'b0, 7'h0, 3'd0, 7'h0, 32'h0, 32'h0, 32'h0);
        step("drain");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 7'h33, 3'd6, 7'h0, 32'(i + 16), 32'(i + 32), 32'h0);
            step("bp");
        end
        chk("bp.in_ready_lit", in_ready, 1'b0);
        set_in(1'b0, 7'h0, 3'd0, 7'h0, 32'h0, 32'h0, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("bp_drain");

        // Illegal opcode
        set_in(1'b1, 7'h7F, 3'd0, 7'h0, 32'h1234, 32'h5678, 32'h9ABC);
        step("ill");
        chk("ill.flag_lit", out_illegal, 1'b1);
        set_in(1'b0, 7'h0, 3'd0, 7'h0, 32'h0, 32'h0, 32'h0);
        step("ill_drain");

        // Fill, then reset asynchronously between edges
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 7'h03, 3'd2, 7'h0, 32'(i + 5), 32'h0, 32'h40);
            step("fill");
        end
        chk("fill.in_ready_lit", in_ready, 1'b0);
        #1 reset = 1'b1;
        #1;
        mq.delete();
        exp_issued  = 0;
        exp_illegal = 0;
        check_state("arst");
        chk("arst.alu_op", alu_op, 3'b010);
        chk("arst.alu_a",  alu_a,  32'h0);
        chk("arst.alu_b",  alu_b,  32'h0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        set_in(1'b1, 7'h13, 3'd7, 7'h0, 32'hF0F0_F0F0, 32'h0, 32'h0FF0_00FF);
        step("post_rst");

        // Streaming legal instructions at full rate
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            rand_instr(1'b1);
            step("stream");
        end

        // Random traffic, including illegal encodings and backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            rand_instr(1'b0);
            step("rand");
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu_issue_stage
`default_nettype wire
